// File: rtl/mac_frame_accum.sv
// Streaming signed MAC: registers a*b, then accumulates it
// with saturation over a frame and holds the frame sum for downstream.

module mult_mnbit_signed #(
  parameter int M = 4,
  parameter int N = 4
) (
  input  logic [M-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [M+N-1:0] p
);
  // full-width signed product
  always_comb begin
    p = $signed(a) * $signed(b);
  end
endmodule

module mac_frame_accum #(
  parameter int W         = 4,
  parameter int FRAME_LEN = 8,
  parameter int ACC_W     = 2*W+2,
  parameter int CW        = $clog2(FRAME_LEN+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CW-1:0]    out_count,
  output logic             out_ovf
);

  localparam logic signed [ACC_W:0] SMAX =
    {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SMIN =
    {2'b11, {(ACC_W-1){1'b0}}};
  localparam logic [CW-1:0] CLAST = CW'(FRAME_LEN-1);

  logic [2*W-1:0]   prod;
  logic             p_valid_q, p_valid_d;
  logic [2*W-1:0]   p_prod_q, p_prod_d;
  logic             p_last_q, p_last_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_acc_q, ovf_acc_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [CW-1:0]    out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;

  logic             closing;
  logic             p_drain;
  logic             accept;
  logic signed [ACC_W:0] sum;
  logic [ACC_W-1:0] clamped;
  logic             clamp;

  mult_mnbit_signed #(.M(W), .N(W)) u_mult (
    .a (in_a),
    .b (in_b),
    .p (prod)
  );

  assign closing  = p_last_q || (cnt_q == CLAST);
  assign p_drain  = p_valid_q &&
                    !(closing && out_valid_q && !out_ready);
  assign in_ready = !p_valid_q || p_drain;
  assign accept   = in_valid && in_ready;

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

  // saturating add of the registered product into the accumulator
  always_comb begin
    sum = $signed({acc_q[ACC_W-1], acc_q}) +
          $signed({{(ACC_W+1-2*W){p_prod_q[2*W-1]}}, p_prod_q});
    clamped = sum[ACC_W-1:0];
    clamp   = 1'b0;
    if (sum > SMAX) begin
      clamped = SMAX[ACC_W-1:0];
      clamp   = 1'b1;
    end else if (sum < SMIN) begin
      clamped = SMIN[ACC_W-1:0];
      clamp   = 1'b1;
    end
  end

  // next state for product, accumulator and output stages
  always_comb begin
    p_valid_d   = p_valid_q;
    p_prod_d    = p_prod_q;
    p_last_d    = p_last_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_acc_d   = ovf_acc_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (p_drain) begin
      p_valid_d = 1'b0;
      if (closing) begin
        out_valid_d = 1'b1;
        out_sum_d   = clamped;
        out_count_d = cnt_q + CW'(1);
        out_ovf_d   = ovf_acc_q | clamp;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_acc_d   = 1'b0;
      end else begin
        acc_d     = clamped;
        cnt_d     = cnt_q + CW'(1);
        ovf_acc_d = ovf_acc_q | clamp;
      end
    end

    if (accept) begin
      p_valid_d = 1'b1;
      p_prod_d  = prod;
      p_last_d  = in_last;
    end
  end

  // state registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_valid_q   <= 1'b0;
      p_prod_q    <= '0;
      p_last_q    <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_acc_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      p_valid_q   <= p_valid_d;
      p_prod_q    <= p_prod_d;
      p_last_q    <= p_last_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_acc_q   <= ovf_acc_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_mac_frame_accum.sv
// Directed bench for mac_frame_accum: hand-computed frame sums,
// saturation, backpressure and mid-frame reset.

module tb_mac_frame_accum;

  localparam int W     = 4;
  localparam int FL    = 8;
  localparam int ACC_W = 2*W+2;
  localparam int CW    = $clog2(FL+1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CW-1:0]    out_count;
  logic             out_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_frame_accum #(.W(W), .FRAME_LEN(FL)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a, input int b, input logic last);
    bit done = 0;
    in_valid = 1'b1;
    in_a     = W'(a);
    in_b     = W'(b);
    in_last  = last;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) done = 1;
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  task automatic out_chk(input string tag, input int s,
                         input int c, input int o);
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_sum"}, 32'($signed(out_sum)), s);
    chk({tag, "_count"}, 32'(out_count), c);
    chk({tag, "_ovf"}, 32'(out_ovf), o);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_last = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_sum", 32'(out_sum), 0);
    chk("rst_out_count", 32'(out_count), 0);
    chk("rst_out_ovf", 32'(out_ovf), 0);
    step();
    chk("rst_in_ready", 32'(in_ready), 1);
    rst = 1'b0;
    step();

    // early close: 6 - 20 + 64 - 7 = 43
    send(3, 2, 0);
    send(-4, 5, 0);
    send(-8, -8, 0);
    send(7, -1, 1);
    step();
    out_chk("early", 43, 4, 0);
    step();
    chk("early_drop", 32'(out_valid), 0);

    send(-8, 7, 1);
    step();
    out_chk("single", -56, 1, 0);

    // 8 x 64 = 512 clamps to 511, closes on count
    for (int i = 0; i < 8; i++) send(-8, -8, 0);
    step();
    out_chk("satpos", 511, 8, 1);
    send(1, 1, 1);
    step();
    out_chk("after_sat", 1, 1, 0);

    for (int i = 0; i < 8; i++) send(-8, 7, 0);
    step();
    out_chk("neg", -448, 8, 0);
    step();

    // backpressure
    out_ready = 1'b0;
    send(2, 3, 1);
    send(1, 1, 0);
    send(1, 1, 1);
    out_chk("bp_hold", 6, 1, 0);
    chk("bp_stall_ready", 32'(in_ready), 0);
    step();
    out_chk("bp_hold2", 6, 1, 0);
    chk("bp_stall_ready2", 32'(in_ready), 0);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 1);
    step();
    out_ready = 1'b0;
    out_chk("bp_reload", 2, 2, 0);
    step();
    out_chk("bp_reload_hold", 2, 2, 0);
    out_ready = 1'b1;
    step();
    chk("bp_drain", 32'(out_valid), 0);

    // reset mid-frame discards the partial frame
    send(5, 5, 0);
    send(5, 5, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_sum", 32'(out_sum), 0);
    chk("mid_rst_count", 32'(out_count), 0);
    chk("mid_rst_ovf", 32'(out_ovf), 0);
    step();
    rst = 1'b0;
    step();
    send(1, 2, 1);
    step();
    out_chk("post_rst", 2, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_frame_accum.md
Name: mac_frame_accum

Overview:
- Streaming signed multiply-accumulate stage with a valid/ready handshake.
- Accepts one pair of signed W-bit operands per beat and multiplies them with an internal instance of mult_mnbit_signed (W, W).
- Registers the product, then accumulates products over a frame with saturation.
- At frame end, presents the sum on a held output register. Sits downstream of the signed multiplier and replaces the combinational four-product mult_add for streamed operands.

Parameters:
- W, 4, operand width (signed, two's complement).
- FRAME_LEN, 8, maximum number of beats per frame.
- ACC_W, 2*W+2, accumulator and output width (signed).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, operand pair valid.
- in_ready, output, 1, stage can accept an operand pair.
- in_a, input, W, signed operand a.
- in_b, input, W, signed operand b.
- in_last, input, 1, this beat closes the frame early.
- out_valid, output, 1, frame result valid.
- out_ready, input, 1, downstream accepts the result.
- out_sum, output, ACC_W, signed saturated frame sum.
- out_count, output, $clog2(FRAME_LEN+1), number of beats in the frame.
- out_ovf, output, 1, saturation occurred in this frame (sticky per frame).

Behaviour:
- Reset (async, active-high): p_valid, acc, cnt, ovf_acc, out_valid, out_sum, out_count and out_ovf all go to 0. in_ready = 1 once the first clock edge has passed.
- Stage P (product register):
  - On in_valid && in_ready, load p_prod = a*b (2W signed), p_last = in_last, p_valid = 1.
  - A beat is "closing" when p_last = 1 or cnt = FRAME_LEN-1. cnt counts beats already accumulated in the current frame.
- Drain condition: p_drain = p_valid && !(closing && out_valid && !out_ready).
- in_ready = !p_valid || p_drain (combinational). Back-to-back beats run at full rate.
- Stage A (accumulate, on p_drain):
  - sum = acc + sign-extended p_prod, computed at ACC_W+1 bits.
  - If sum > 2^(ACC_W-1)-1, clamp to that value. If sum < -2^(ACC_W-1), clamp to that value. Either clamp sets the overflow flag for this frame.
  - Accumulation continues from the clamped value.
- Non-closing beat: acc = clamped sum, cnt++, ovf_acc |= clamp.
- Closing beat:
  - out_sum = clamped sum, out_count = cnt+1, out_ovf = ovf_acc | clamp, out_valid = 1.
  - acc, cnt and ovf_acc are cleared, so the next beat starts a new frame.
- Output handshake:
  - out_valid stays high and out_* stay stable until out_valid && out_ready.
  - On that handshake with no simultaneous closing beat, out_valid falls next cycle.
  - On that handshake with a simultaneous closing drain, the output reloads the new frame and out_valid stays 1.
- Latency:
  - Input accepted at edge N gives the product at edge N; it is accumulated at edge N+1.
  - If that beat is closing, out_valid is visible after edge N+1, with no stall.
- in_last on the FRAME_LEN-th beat closes the frame exactly once; no empty frame is produced.
- Frames never exceed FRAME_LEN beats. The beat after a forced close starts a fresh frame regardless of in_last.
- in_valid without in_ready: the beat is not consumed and the source holds its data.
- Reset mid-frame or mid-stall: all partial state and any pending output are discarded. No output is produced for the interrupted frame.

Test Plan:
- Early-close frame: beats (3,2), (-4,5), (-8,-8), (7,-1), with in_last on the 4th and out_ready=1. Required: one cycle after the 4th accept, out_valid=1, out_sum=43, out_count=4, out_ovf=0.
- Single-beat frame: (-8,7) with in_last=1. Required: out_sum=-56, out_count=1, out_ovf=0.
- Positive saturation: 8 beats of (-8,-8) with in_last=0. Required: frame closes on count, out_sum=511 (clamped from 512), out_count=8, out_ovf=1. The next frame of (1,1) with in_last gives 1, ovf=0.
- Backpressure: out_ready=0, frame A = (2,3) last, then frame B = (1,1),(1,1) last.
  - Required: A is held at 6. B's closing beat stalls in P with in_ready=0.
  - Raise out_ready for one cycle: A is accepted and out_sum becomes 2 in the same edge, with out_valid staying 1.
- Negative range: 8 beats of (-8,7). Required: out_sum=-448, out_ovf=0.
- Reset mid-frame: accept (5,5),(5,5), assert rst for one cycle, then send (1,2) last. Required: all outputs 0 during reset, and the next result is out_sum=2, out_count=1.
